// File: rtl/ftdi_pkg.sv
// Shared types for the FT232H 245-synchronous-FIFO arbiter.
package ftdi_pkg;

  localparam int unsigned FTDI_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_OE    = 3'd1,
    RX_READ  = 3'd2,
    TX_WRITE = 3'd3,
    GAP      = 3'd4
  } state_e;

  typedef enum logic {
    DIR_RX = 1'b0,
    DIR_TX = 1'b1
  } dir_e;

endpackage

// File: rtl/ftdi_fifo_arbiter_if.sv
// FTDI pin-side and panel-FIFO-side signals of the arbiter.
interface ftdi_fifo_arbiter_if;
  import ftdi_pkg::*;

  logic              rxf_n;
  logic              txe_n;
  logic [FTDI_W-1:0] ftdi_data_i;
  logic [FTDI_W-1:0] ftdi_data_o;
  logic              ftdi_data_oe;
  logic              oe_n;
  logic              rd_n;
  logic              wr_n;
  logic              rx_afull;
  logic [FTDI_W-1:0] rx_data;
  logic              rx_valid;
  logic [FTDI_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  rxf_n, txe_n, ftdi_data_i, rx_afull, tx_data, tx_valid,
    output ftdi_data_o, ftdi_data_oe, oe_n, rd_n, wr_n, rx_data, rx_valid, tx_ready
  );

  modport slave (
    output rxf_n, txe_n, ftdi_data_i, rx_afull, tx_data, tx_valid,
    input  ftdi_data_o, ftdi_data_oe, oe_n, rd_n, wr_n, rx_data, rx_valid, tx_ready
  );

endinterface

// File: rtl/ftdi_fifo_arbiter.sv
// Half-duplex FT232H bus sequencer: fair, burst-bounded sharing between the
// host->FPGA receive stream and the FPGA->host transmit stream.
module ftdi_fifo_arbiter
  import ftdi_pkg::*;
#(
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                clk_60,
  input  logic                rst_n,
  ftdi_fifo_arbiter_if.master bus
);

  localparam int unsigned       CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  state_e            state_q, state_d;
  dir_e              last_dir_q, last_dir_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [FTDI_W-1:0] rx_data_q;
  logic              rx_valid_q;

  logic              rx_pend, tx_pend;
  logic              rx_take, tx_take;
  logic              oe_n_c, rd_n_c, wr_n_c, tx_ready_c, data_oe_c;
  logic [FTDI_W-1:0] data_o_c;

  assign rx_pend = !bus.rxf_n && !bus.rx_afull;
  assign tx_pend = bus.tx_valid && !bus.txe_n;

  // State, fairness and burst bookkeeping
  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_dir_q  <= DIR_TX;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      last_dir_q  <= last_dir_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next state and bus strobes; rd_n/wr_n follow the pending flags so a
  // flag dropping mid-burst blocks the transfer on that same edge.
  always_comb begin
    state_d     = state_q;
    last_dir_d  = last_dir_q;
    burst_cnt_d = burst_cnt_q;
    oe_n_c      = 1'b1;
    rd_n_c      = 1'b1;
    wr_n_c      = 1'b1;
    tx_ready_c  = 1'b0;
    data_oe_c   = 1'b0;
    data_o_c    = '0;
    rx_take     = 1'b0;
    tx_take     = 1'b0;

    unique case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (rx_pend && (!tx_pend || (last_dir_q == DIR_TX))) begin
          state_d    = RX_OE;
          last_dir_d = DIR_RX;
        end else if (tx_pend) begin
          state_d    = TX_WRITE;
          last_dir_d = DIR_TX;
        end
      end

      RX_OE: begin
        oe_n_c  = 1'b0;
        state_d = RX_READ;
      end

      RX_READ: begin
        oe_n_c  = 1'b0;
        rd_n_c  = !rx_pend;
        rx_take = rx_pend;
        if (rx_take) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        if (!rx_pend || (burst_cnt_q == LAST_CNT)) begin
          state_d = GAP;
        end
      end

      TX_WRITE: begin
        data_oe_c  = 1'b1;
        data_o_c   = bus.tx_data;
        wr_n_c     = !tx_pend;
        tx_ready_c = tx_pend;
        tx_take    = tx_pend;
        if (tx_take) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
        if (!tx_pend || (burst_cnt_q == LAST_CNT)) begin
          state_d = GAP;
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Received byte is pushed downstream the cycle after the read edge
  always_ff @(posedge clk_60 or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= rx_take;
      if (rx_take) begin
        rx_data_q <= bus.ftdi_data_i;
      end
    end
  end

  assign bus.oe_n         = oe_n_c;
  assign bus.rd_n         = rd_n_c;
  assign bus.wr_n         = wr_n_c;
  assign bus.tx_ready     = tx_ready_c;
  assign bus.ftdi_data_oe = data_oe_c;
  assign bus.ftdi_data_o  = data_o_c;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;

endmodule

// File: tb/tb_ftdi_fifo_arbiter.sv
// Directed bench for ftdi_fifo_arbiter: an FT232H/FIFO environment model
// around a MAX_BURST=64 instance plus a MAX_BURST=4 fairness instance.
module tb_ftdi_fifo_arbiter;

  logic clk_60 = 1'b0;
  logic rst_n;

  always #8 clk_60 = ~clk_60;

  ftdi_fifo_arbiter_if bus ();
  ftdi_fifo_arbiter_if bus4 ();

  ftdi_fifo_arbiter #(.MAX_BURST(64)) dut (
    .clk_60 (clk_60),
    .rst_n  (rst_n),
    .bus    (bus.master)
  );

  ftdi_fifo_arbiter #(.MAX_BURST(4)) dut4 (
    .clk_60 (clk_60),
    .rst_n  (rst_n),
    .bus    (bus4.master)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [7:0] rx_q[$], tx_q[$], rx_got[$], wr_got[$], exp_rx[$], exp_wr[$];
  int         rx_pops, tx_pops;
  logic       rx_hold, tx_block, rx_full;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FTDI chip and panel FIFO outputs derived from the model queues
  task automatic apply();
    bus.rxf_n       = rx_hold || (rx_q.size() == 0);
    bus.ftdi_data_i = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    bus.tx_valid    = (tx_q.size() != 0);
    bus.tx_data     = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    bus.txe_n       = tx_block;
    bus.rx_afull    = rx_full;
  endtask

  task automatic upd();
    apply();
    #1;
  endtask

  // One clock: sample handshakes before the edge, update the model after it
  task automatic tick();
    logic s_rd, s_wr, s_pop;
    logic [7:0] s_dat;
    #1;
    check("excl_oe", 32'(!bus.oe_n && bus.ftdi_data_oe), 32'd0);
    check("rd_without_oe", 32'(!bus.rd_n && bus.oe_n), 32'd0);
    check("excl_oe_b4", 32'(!bus4.oe_n && bus4.ftdi_data_oe), 32'd0);
    s_rd  = !bus.rd_n && !bus.rxf_n;
    s_wr  = !bus.wr_n && !bus.txe_n;
    s_pop = bus.tx_valid && bus.tx_ready;
    s_dat = bus.ftdi_data_o;
    @(posedge clk_60);
    #1;
    if (s_rd) begin
      void'(rx_q.pop_front());
      rx_pops++;
    end
    if (s_wr) wr_got.push_back(s_dat);
    if (s_pop) begin
      void'(tx_q.pop_front());
      tx_pops++;
    end
    if (bus.rx_valid) rx_got.push_back(bus.rx_data);
    apply();
    #1;
  endtask

  task automatic clear_streams();
    rx_got.delete(); wr_got.delete(); exp_rx.delete(); exp_wr.delete();
    rx_pops = 0;
    tx_pops = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (rx_q.size() != 0 || tx_q.size() != 0); n++) tick();
    check("drain_done", 32'(rx_q.size() + tx_q.size()), 32'd0);
    repeat (4) tick();
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 40 && rx_pops < n; i++) tick();
    check("wait_rx_pops", 32'(rx_pops), 32'(n));
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 40 && tx_pops < n; i++) tick();
    check("wait_tx_pops", 32'(tx_pops), 32'(n));
  endtask

  task automatic compare_streams(input string tag);
    check({tag, "_rx_count"}, 32'(rx_got.size()), 32'(exp_rx.size()));
    for (int i = 0; i < exp_rx.size() && i < rx_got.size(); i++)
      check({tag, "_rx_byte"}, 32'(rx_got[i]), 32'(exp_rx[i]));
    check({tag, "_wr_count"}, 32'(wr_got.size()), 32'(exp_wr.size()));
    check({tag, "_pop_count"}, 32'(tx_pops), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_got.size(); i++)
      check({tag, "_wr_byte"}, 32'(wr_got[i]), 32'(exp_wr[i]));
  endtask

  // {oe_n, rd_n, wr_n, ftdi_data_oe}: idle/gap=E, RX_OE=6, RX_READ=2, TX_WRITE=D
  logic [3:0] fair_exp [0:18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fair_rxv, fair_pop;
    fair_exp = '{4'hE, 4'h6, 4'h2, 4'h2, 4'h2, 4'h2, 4'hE, 4'hE, 4'hD, 4'hD,
                 4'hD, 4'hD, 4'hE, 4'hE, 4'h6, 4'h2, 4'h2, 4'h2, 4'h2};
    rst_n = 1'b0;
    rx_hold = 1'b0; tx_block = 1'b0; rx_full = 1'b0;
    clear_streams();
    apply();
    bus4.rxf_n = 1'b0; bus4.txe_n = 1'b0; bus4.tx_valid = 1'b1;
    bus4.tx_data = 8'hC3; bus4.ftdi_data_i = 8'h5A; bus4.rx_afull = 1'b0;
    repeat (2) tick();

    check("rst_oe_n", 32'(bus.oe_n), 32'd1);
    check("rst_rd_n", 32'(bus.rd_n), 32'd1);
    check("rst_wr_n", 32'(bus.wr_n), 32'd1);
    check("rst_data_oe", 32'(bus.ftdi_data_oe), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_b4_strobes", 32'({bus4.oe_n, bus4.rd_n, bus4.wr_n, bus4.ftdi_data_oe}), 32'hE);

    // Fairness, MAX_BURST=4, both directions pending continuously
    rst_n = 1'b1;
    #1;
    fair_rxv = 0;
    fair_pop = 0;
    for (int c = 0; c < 19; c++) begin
      if (c != 0) tick();
      check("fair_strobes", 32'({bus4.oe_n, bus4.rd_n, bus4.wr_n, bus4.ftdi_data_oe}),
            32'(fair_exp[c]));
      if (bus4.rx_valid) fair_rxv++;
      if (bus4.tx_ready) fair_pop++;
    end
    check("fair_rx_valid_count", 32'(fair_rxv), 32'd7);
    check("fair_tx_pop_count", 32'(fair_pop), 32'd4);
    check("fair_rx_data", 32'(bus4.rx_data), 32'h5A);
    bus4.rxf_n = 1'b1;
    bus4.tx_valid = 1'b0;
    repeat (3) tick();

    // Single RX burst FF,01..07
    clear_streams();
    for (int i = 0; i < 8; i++) begin
      rx_q.push_back((i == 0) ? 8'hFF : 8'(i));
      exp_rx.push_back((i == 0) ? 8'hFF : 8'(i));
    end
    upd();
    check("rx1_idle_oe_n", 32'(bus.oe_n), 32'd1);
    tick();
    check("rx1_oe_first", 32'(bus.oe_n), 32'd0);
    check("rx1_rd_after_oe", 32'(bus.rd_n), 32'd1);
    tick();
    check("rx1_rd_low", 32'(bus.rd_n), 32'd0);
    repeat (8) tick();
    check("rx1_rd_rise", 32'(bus.rd_n), 32'd1);
    check("rx1_oe_held", 32'(bus.oe_n), 32'd0);
    check("rx1_last_valid", 32'(bus.rx_valid), 32'd1);
    tick();
    check("rx1_gap_oe_n", 32'(bus.oe_n), 32'd1);
    check("rx1_gap_valid", 32'(bus.rx_valid), 32'd0);
    drain();
    compare_streams("rx1");

    // TX burst A0..A4
    clear_streams();
    for (int i = 0; i < 5; i++) begin
      tx_q.push_back(8'hA0 + 8'(i));
      exp_wr.push_back(8'hA0 + 8'(i));
    end
    upd();
    check("tx1_idle_wr_n", 32'(bus.wr_n), 32'd1);
    tick();
    check("tx1_wr_low", 32'(bus.wr_n), 32'd0);
    check("tx1_drive", 32'(bus.ftdi_data_oe), 32'd1);
    check("tx1_oe_n_high", 32'(bus.oe_n), 32'd1);
    check("tx1_data_o", 32'(bus.ftdi_data_o), 32'hA0);
    repeat (5) tick();
    check("tx1_wr_rise", 32'(bus.wr_n), 32'd1);
    check("tx1_still_drive", 32'(bus.ftdi_data_oe), 32'd1);
    tick();
    check("tx1_gap_release", 32'(bus.ftdi_data_oe), 32'd0);
    drain();
    compare_streams("tx1");

    // RX flow control: afull after byte 3
    clear_streams();
    for (int i = 0; i < 6; i++) begin
      rx_q.push_back(8'h10 + 8'(i));
      exp_rx.push_back(8'h10 + 8'(i));
    end
    upd();
    wait_rx(3);
    rx_full = 1'b1;
    upd();
    check("afull_rd_high", 32'(bus.rd_n), 32'd1);
    repeat (3) tick();
    check("afull_no_extra", 32'(rx_got.size()), 32'd3);
    rx_full = 1'b0;
    upd();
    drain();
    compare_streams("afull");

    // TX flow control: txe_n rises after 2 bytes
    clear_streams();
    for (int i = 0; i < 6; i++) begin
      tx_q.push_back(8'hB0 + 8'(i));
      exp_wr.push_back(8'hB0 + 8'(i));
    end
    upd();
    wait_tx(2);
    tx_block = 1'b1;
    upd();
    check("txe_wr_high", 32'(bus.wr_n), 32'd1);
    check("txe_no_pop", 32'(bus.tx_ready), 32'd0);
    repeat (3) tick();
    check("txe_pops_held", 32'(tx_pops), 32'd2);
    check("txe_writes_held", 32'(wr_got.size()), 32'd2);
    tx_block = 1'b0;
    upd();
    drain();
    compare_streams("txe");

    // Interrupted read: rxf_n high after 7 bytes for 4 cycles
    clear_streams();
    for (int i = 0; i < 11; i++) begin
      rx_q.push_back(8'h20 + 8'(i));
      exp_rx.push_back(8'h20 + 8'(i));
    end
    upd();
    wait_rx(7);
    rx_hold = 1'b1;
    upd();
    check("intr_rd_high", 32'(bus.rd_n), 32'd1);
    tick();
    check("intr_gap", 32'(bus.oe_n), 32'd1);
    repeat (3) tick();
    rx_hold = 1'b0;
    upd();
    tick();
    check("intr_new_rx_oe", 32'(bus.oe_n), 32'd0);
    check("intr_new_rd_high", 32'(bus.rd_n), 32'd1);
    drain();
    compare_streams("intr");

    // Reset mid RX burst, then RX wins the tie
    clear_streams();
    for (int i = 0; i < 10; i++) rx_q.push_back(8'h30 + 8'(i));
    for (int i = 3; i < 10; i++) exp_rx.push_back(8'h30 + 8'(i));
    upd();
    wait_rx(3);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_q.push_back(8'hC0 + 8'(i));
      exp_wr.push_back(8'hC0 + 8'(i));
    end
    upd();
    check("mrst_oe_n", 32'(bus.oe_n), 32'd1);
    check("mrst_rd_n", 32'(bus.rd_n), 32'd1);
    check("mrst_wr_n", 32'(bus.wr_n), 32'd1);
    check("mrst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("mrst_rx_data", 32'(bus.rx_data), 32'd0);
    repeat (2) tick();
    rx_got.delete();
    rst_n = 1'b1;
    upd();
    check("mrst_idle", 32'(bus.oe_n), 32'd1);
    tick();
    check("mrst_rx_first", 32'(bus.oe_n), 32'd0);
    check("mrst_no_drive", 32'(bus.ftdi_data_oe), 32'd0);
    drain();
    compare_streams("mrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
